mac_table_aging: RTL and testbench

MAC_TABLE_AGING -- requirements
Module: mac_table_aging

---
 rtl/mac_table_pkg.sv | 22 ++
 rtl/mac_table_aging_if.sv | 40 ++++
 rtl/age_tick_gen.sv | 40 ++++
 rtl/mac_table_aging.sv | 171 +++++++++++++++++
 tb/tb_mac_table_aging.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_table_pkg.sv
`default_nettype none
// ============================================================================
// Module : mac_table_pkg
// Brief  : Shared scan-state encoding and width helper for the MAC table.
// Rev    : 1.0
// ============================================================================
package mac_table_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

   localparam int unsigned C_MIN_WIDTH = 1;

   // Bit width to address n items, never narrower than one bit
   function automatic int unsigned fn_width(input int unsigned n);
      return (n < 2) ? C_MIN_WIDTH : $clog2(n);
   endfunction

endpackage : mac_table_pkg
`default_nettype wire

// File: rtl/mac_table_aging_if.sv
`default_nettype none
// ============================================================================
// Module : mac_table_aging_if
// Brief  : Learn/lookup request and response bundle of the MAC aging table.
// Rev    : 1.0
// ============================================================================
interface mac_table_aging_if
   import mac_table_pkg::*;
#(
   parameter int unsigned pPORT_NUM      = 4,
   parameter int unsigned pMAC_MEM_DEPTH = 256,
   parameter int unsigned pLKP_CH        = 4
);
   localparam int unsigned PW = fn_width(pPORT_NUM);
   localparam int unsigned AW = fn_width(pMAC_MEM_DEPTH);

   logic                  learn_valid;
   logic [AW-1:0]         learn_idx;
   logic [PW-1:0]         learn_port;
   logic [pLKP_CH-1:0]    lkp_req_valid;
   logic [pLKP_CH*AW-1:0] lkp_req_idx;
   logic [pLKP_CH-1:0]    lkp_rsp_valid;
   logic [pLKP_CH-1:0]    lkp_rsp_hit;
   logic [pLKP_CH*PW-1:0] lkp_rsp_port;
   logic                  move;
   logic [AW:0]           entry_count;
   logic                  scan_busy;

   modport master (
      output learn_valid, learn_idx, learn_port, lkp_req_valid, lkp_req_idx,
      input  lkp_rsp_valid, lkp_rsp_hit, lkp_rsp_port, move, entry_count, scan_busy
   );

   modport slave (
      input  learn_valid, learn_idx, learn_port, lkp_req_valid, lkp_req_idx,
      output lkp_rsp_valid, lkp_rsp_hit, lkp_rsp_port, move, entry_count, scan_busy
   );

endinterface : mac_table_aging_if
`default_nettype wire

// File: rtl/age_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : age_tick_gen
// Brief  : Free-running 0..pTICK_CYCLES-1 counter, one-cycle tick on wrap.
// Rev    : 1.0
// ============================================================================
module age_tick_gen
   import mac_table_pkg::*;
#(
   parameter int unsigned pTICK_CYCLES = 32768
) (
   input  wire logic iclk,
   input  wire logic i_rst_n,
   output logic      o_tick
);
   localparam int unsigned       CW       = fn_width(pTICK_CYCLES);
   localparam logic [CW-1:0]     CNT_LAST = CW'(pTICK_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge iclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = (cnt_q == CNT_LAST);

endmodule : age_tick_gen
`default_nettype wire

// File: rtl/mac_table_aging.sv
`default_nettype none
// ============================================================================
// Module : mac_table_aging
// Brief  : MAC learning table with multi-channel lookup and background aging.
// Rev    : 1.0
// ============================================================================
module mac_table_aging
   import mac_table_pkg::*;
#(
   parameter int unsigned pPORT_NUM      = 4,
   parameter int unsigned pMAC_MEM_DEPTH = 256,
   parameter int unsigned pLKP_CH        = 4,
   parameter int unsigned pAGE_MAX       = 300,
   parameter int unsigned pTICK_CYCLES   = 32768
) (
   input  wire logic                                               iclk,
   input  wire logic                                               i_rst_n,
   input  wire logic                                               i_learn_valid,
   input  wire logic [fn_width(pMAC_MEM_DEPTH)-1:0]                i_learn_idx,
   input  wire logic [fn_width(pPORT_NUM)-1:0]                     i_learn_port,
   input  wire logic [pLKP_CH-1:0]                                 i_lkp_valid,
   input  wire logic [pLKP_CH*fn_width(pMAC_MEM_DEPTH)-1:0]        i_lkp_idx,
   output logic      [pLKP_CH-1:0]                                 o_lkp_valid,
   output logic      [pLKP_CH-1:0]                                 o_lkp_hit,
   output logic      [pLKP_CH*fn_width(pPORT_NUM)-1:0]             o_lkp_port,
   output logic                                                    o_move,
   output logic      [fn_width(pMAC_MEM_DEPTH):0]                  o_entry_count,
   output logic                                                    o_scan_busy
);
   localparam int unsigned   PW         = fn_width(pPORT_NUM);
   localparam int unsigned   AW         = fn_width(pMAC_MEM_DEPTH);
   localparam int unsigned   GW         = fn_width(pAGE_MAX + 1);
   localparam logic [GW-1:0] AGE_RELOAD = GW'(pAGE_MAX);
   localparam logic [AW-1:0] PTR_LAST   = AW'(pMAC_MEM_DEPTH - 1);

   logic [pMAC_MEM_DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]             port_q [pMAC_MEM_DEPTH];
   logic [GW-1:0]             age_q  [pMAC_MEM_DEPTH];

   scan_state_e               state_q, state_d;
   logic [AW-1:0]             ptr_q, ptr_d;
   logic                      pend_q, pend_d;
   logic [AW:0]               count_q, count_d;
   logic                      move_q, move_d;
   logic [pLKP_CH-1:0]        lkp_valid_q;
   logic [pLKP_CH-1:0]        lkp_hit_q, lkp_hit_d;
   logic [pLKP_CH*PW-1:0]     lkp_port_q, lkp_port_d;
   logic [AW-1:0]             lkp_idx_d;

   logic                      tick;
   logic                      scan_visit, learn_at_ptr, age_dec, expire, learn_new;

   age_tick_gen #(
      .pTICK_CYCLES (pTICK_CYCLES)
   ) u_age_tick_gen (
      .iclk    (iclk),
      .i_rst_n (i_rst_n),
      .o_tick  (tick)
   );

   // A learn on the visited entry overrides the scan's effect on it
   assign scan_visit   = (state_q == ST_SCAN) && valid_q[ptr_q];
   assign learn_at_ptr = i_learn_valid && (i_learn_idx == ptr_q);
   assign age_dec      = scan_visit && !learn_at_ptr && (age_q[ptr_q] >  GW'(1));
   assign expire       = scan_visit && !learn_at_ptr && (age_q[ptr_q] <= GW'(1));
   assign learn_new    = i_learn_valid && !valid_q[i_learn_idx];

   always_comb begin
      valid_d = valid_q;
      if (expire) begin
         valid_d[ptr_q] = 1'b0;
      end
      if (i_learn_valid) begin
         valid_d[i_learn_idx] = 1'b1;
      end
      count_d = count_q;
      case ({learn_new, expire})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      move_d = i_learn_valid && valid_q[i_learn_idx] &&
               (port_q[i_learn_idx] != i_learn_port);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (tick || pend_q) begin
               state_d = ST_SCAN;
               ptr_d   = '0;
               pend_d  = 1'b0;
            end
         end
         ST_SCAN: begin
            ptr_d = ptr_q + AW'(1);
            if (tick) begin
               pend_d = 1'b1;
            end
            if (ptr_q == PTR_LAST) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Lookups read the pre-edge table, so a same-cycle learn is not seen
   always_comb begin
      lkp_hit_d  = '0;
      lkp_port_d = '0;
      lkp_idx_d  = '0;
      for (int c = 0; c < pLKP_CH; c++) begin
         lkp_idx_d    = i_lkp_idx[c*AW +: AW];
         lkp_hit_d[c] = i_lkp_valid[c] && valid_q[lkp_idx_d];
         if (lkp_hit_d[c]) begin
            lkp_port_d[c*PW +: PW] = port_q[lkp_idx_d];
         end
      end
   end

   always_ff @(posedge iclk) begin
      if (age_dec) begin
         age_q[ptr_q] <= age_q[ptr_q] - GW'(1);
      end
      if (i_learn_valid) begin
         port_q[i_learn_idx] <= i_learn_port;
         age_q[i_learn_idx]  <= AGE_RELOAD;
      end
   end

   always_ff @(posedge iclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q     <= '0;
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         pend_q      <= 1'b0;
         count_q     <= '0;
         move_q      <= 1'b0;
         lkp_valid_q <= '0;
         lkp_hit_q   <= '0;
         lkp_port_q  <= '0;
      end else begin
         valid_q     <= valid_d;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         pend_q      <= pend_d;
         count_q     <= count_d;
         move_q      <= move_d;
         lkp_valid_q <= i_lkp_valid;
         lkp_hit_q   <= lkp_hit_d;
         lkp_port_q  <= lkp_port_d;
      end
   end

   assign o_lkp_valid   = lkp_valid_q;
   assign o_lkp_hit     = lkp_hit_q;
   assign o_lkp_port    = lkp_port_q;
   assign o_move        = move_q;
   assign o_entry_count = count_q;
   assign o_scan_busy   = (state_q == ST_SCAN);

endmodule : mac_table_aging
`default_nettype wire

// File: tb/tb_mac_table_aging.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_table_aging
// Brief  : Directed self-checking bench for mac_table_aging (16 entries, age 3).
// Rev    : 1.0
// ============================================================================
module tb_mac_table_aging;
   localparam int unsigned C_PORTS = 4;
   localparam int unsigned C_DEPTH = 16;
   localparam int unsigned C_CH    = 4;
   localparam int unsigned C_AGE   = 3;
   localparam int unsigned C_TICK  = 32;
   localparam int          C_BOUND = 200;

   logic iclk;
   logic rst_n;
   int   checks;
   int   errors;

   mac_table_aging_if #(
      .pPORT_NUM      (C_PORTS),
      .pMAC_MEM_DEPTH (C_DEPTH),
      .pLKP_CH        (C_CH)
   ) bus ();

   mac_table_aging #(
      .pPORT_NUM      (C_PORTS),
      .pMAC_MEM_DEPTH (C_DEPTH),
      .pLKP_CH        (C_CH),
      .pAGE_MAX       (C_AGE),
      .pTICK_CYCLES   (C_TICK)
   ) dut (
      .iclk          (iclk),
      .i_rst_n       (rst_n),
      .i_learn_valid (bus.learn_valid),
      .i_learn_idx   (bus.learn_idx),
      .i_learn_port  (bus.learn_port),
      .i_lkp_valid   (bus.lkp_req_valid),
      .i_lkp_idx     (bus.lkp_req_idx),
      .o_lkp_valid   (bus.lkp_rsp_valid),
      .o_lkp_hit     (bus.lkp_rsp_hit),
      .o_lkp_port    (bus.lkp_rsp_port),
      .o_move        (bus.move),
      .o_entry_count (bus.entry_count),
      .o_scan_busy   (bus.scan_busy)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_busy(input string tag, input logic level);
      int n;
      n = 0;
      while ((bus.scan_busy !== level) && (n < C_BOUND)) begin
         step();
         n++;
      end
      chk(tag, {31'd0, bus.scan_busy}, {31'd0, level});
   endtask

   task automatic wait_scan_end(input string tag);
      wait_busy({tag, "_start"}, 1'b1);
      wait_busy({tag, "_end"}, 1'b0);
   endtask

   task automatic learn(input logic [3:0] idx, input logic [1:0] port);
      bus.learn_valid = 1'b1;
      bus.learn_idx   = idx;
      bus.learn_port  = port;
      step();
      bus.learn_valid = 1'b0;
   endtask

   task automatic lookup(input logic [3:0] vld, input logic [15:0] idx);
      bus.lkp_req_valid = vld;
      bus.lkp_req_idx   = idx;
      step();
      bus.lkp_req_valid = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.learn_valid   = 1'b0;
      bus.learn_idx     = '0;
      bus.learn_port    = '0;
      bus.lkp_req_valid = '0;
      bus.lkp_req_idx   = '0;
      step();
      step();
      chk("rst_count", 32'(bus.entry_count), 32'd0);
      chk("rst_busy",  32'(bus.scan_busy),   32'd0);
      chk("rst_lkpv",  32'(bus.lkp_rsp_valid), 32'd0);
      chk("rst_move",  32'(bus.move),        32'd0);
      rst_n = 1'b1;
      step();

      // basic learn and four-channel lookup
      learn(4'd5, 2'd2);
      lookup(4'hF, 16'h5555);
      chk("lkp5_valid", 32'(bus.lkp_rsp_valid), 32'hF);
      chk("lkp5_hit",   32'(bus.lkp_rsp_hit),   32'hF);
      chk("lkp5_port",  32'(bus.lkp_rsp_port),  32'hAA);
      chk("lkp5_count", 32'(bus.entry_count),   32'd1);
      step();
      chk("lkp_idle_valid", 32'(bus.lkp_rsp_valid), 32'h0);

      // mixed channels: ch0/ch2 miss on idx 9, ch1 hits idx 5, ch3 idle
      lookup(4'b0111, 16'h5959);
      chk("mix_valid", 32'(bus.lkp_rsp_valid), 32'h7);
      chk("mix_hit",   32'(bus.lkp_rsp_hit),   32'h2);
      chk("mix_port",  32'(bus.lkp_rsp_port),  32'h08);

      // station move
      learn(4'd5, 2'd3);
      chk("move_pulse", 32'(bus.move),        32'd1);
      chk("move_count", 32'(bus.entry_count), 32'd1);
      step();
      chk("move_clear", 32'(bus.move), 32'd0);
      lookup(4'hF, 16'h5555);
      chk("move_port",  32'(bus.lkp_rsp_port), 32'hFF);
      learn(4'd5, 2'd3);
      chk("same_port_nomove", 32'(bus.move), 32'd0);

      // read-before-write on a same-cycle learn and lookup
      bus.lkp_req_valid = 4'b0001;
      bus.lkp_req_idx   = 16'h000A;
      learn(4'd10, 2'd1);
      bus.lkp_req_valid = '0;
      chk("rbw_hit",   32'(bus.lkp_rsp_hit),  32'h0);
      chk("rbw_port",  32'(bus.lkp_rsp_port), 32'h0);
      chk("rbw_count", 32'(bus.entry_count),  32'd2);
      lookup(4'b0001, 16'h000A);
      chk("rbw_after_hit",  32'(bus.lkp_rsp_hit),  32'h1);
      chk("rbw_after_port", 32'(bus.lkp_rsp_port), 32'h01);

      // reset in the middle of a scan
      learn(4'd1, 2'd0);
      chk("pre_rst_count", 32'(bus.entry_count), 32'd3);
      wait_busy("rst_scan_start", 1'b1);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(bus.entry_count), 32'd0);
      chk("mid_rst_busy",  32'(bus.scan_busy),   32'd0);
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("post_rst_busy", 32'(bus.scan_busy), 32'd0);
      lookup(4'hF, 16'h31A5);
      chk("post_rst_valid", 32'(bus.lkp_rsp_valid), 32'hF);
      chk("post_rst_hit",   32'(bus.lkp_rsp_hit),   32'h0);
      chk("post_rst_port",  32'(bus.lkp_rsp_port),  32'h0);

      // plain aging: entry 7 survives two scans and expires on the third
      wait_scan_end("age_sync");
      learn(4'd7, 2'd1);
      chk("age_count1", 32'(bus.entry_count), 32'd1);
      wait_scan_end("age_s1");
      lookup(4'b0001, 16'h0007);
      chk("age_s1_hit", 32'(bus.lkp_rsp_hit), 32'h1);
      wait_scan_end("age_s2");
      lookup(4'b0001, 16'h0007);
      chk("age_s2_hit",  32'(bus.lkp_rsp_hit),  32'h1);
      chk("age_s2_port", 32'(bus.lkp_rsp_port), 32'h01);
      wait_scan_end("age_s3");
      lookup(4'b0001, 16'h0007);
      chk("age_s3_hit",   32'(bus.lkp_rsp_hit),  32'h0);
      chk("age_s3_count", 32'(bus.entry_count),  32'd0);

      // learn collides with the scan visit of entry 7; entry 8 keeps aging
      learn(4'd7, 2'd2);
      learn(4'd8, 2'd0);
      chk("col_count2", 32'(bus.entry_count), 32'd2);
      wait_busy("col_start", 1'b1);
      repeat (7) step();
      learn(4'd7, 2'd2);
      chk("col_nomove", 32'(bus.move),        32'd0);
      chk("col_count",  32'(bus.entry_count), 32'd2);
      wait_scan_end("col_s1");
      wait_scan_end("col_s2");
      wait_scan_end("col_s3");
      lookup(4'b0011, 16'h0087);
      chk("col_s3_valid", 32'(bus.lkp_rsp_valid), 32'h3);
      chk("col_s3_hit",   32'(bus.lkp_rsp_hit),   32'h1);
      chk("col_s3_port",  32'(bus.lkp_rsp_port),  32'h02);
      chk("col_s3_count", 32'(bus.entry_count),   32'd1);
      wait_scan_end("col_s4");
      lookup(4'b0001, 16'h0007);
      chk("col_s4_hit",   32'(bus.lkp_rsp_hit), 32'h0);
      chk("col_s4_count", 32'(bus.entry_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mac_table_aging
`default_nettype wire
